// File: rtl/uart_mem_loader_pkg.sv
// -----------------------------------------------------------------------------
// uart_mem_loader_pkg
// Shared definitions for the UART program loader:
//   - loader state encoding
//   - framing constants (2-byte little-endian word count header, 1-byte trailer)
//   - checksum helper and a state classification helper
// -----------------------------------------------------------------------------
package uart_mem_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_LO  = 3'd1,
    ST_LEN_HI  = 3'd2,
    ST_DATA_LO = 3'd3,
    ST_DATA_HI = 3'd4,
    ST_CHK     = 3'd5,
    ST_DONE    = 3'd6,
    ST_ERROR   = 3'd7
  } state_t;

  // Frame layout: header carries the word count, trailer carries the XOR of
  // every payload byte (header bytes are not covered).
  localparam int HDR_BYTES  = 2;
  localparam int TRL_BYTES  = 1;
  localparam int WORD_BYTES = 2;

  // Running XOR checksum over payload bytes.
  function automatic logic [7:0] chk_update(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  // A load is in progress in every state except the three resting states.
  function automatic logic is_busy(input state_t s);
    logic r;
    case (s)
      ST_IDLE, ST_DONE, ST_ERROR: r = 1'b0;
      default:                    r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_mem_loader_if.sv
// -----------------------------------------------------------------------------
// uart_mem_loader_if
// Bundles the receiver byte stream and the memory write port seen by the
// loader.
//   rx_data_ready : one-cycle strobe, rx_byte valid
//   rx_byte       : received byte
//   rx_idle       : receiver line-idle (gap) indication
//   mem_we        : memory write strobe, one cycle per word
//   mem_addr      : write word address (ADDR_W bits)
//   mem_wdata     : write data {high byte, low byte}
// Modports:
//   master : the loader (consumes rx, drives memory writes)
//   slave  : the environment (drives rx, receives memory writes)
// -----------------------------------------------------------------------------
interface uart_mem_loader_if #(
  parameter int ADDR_W = 12
);

  logic              rx_data_ready;
  logic [7:0]        rx_byte;
  logic              rx_idle;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;

  modport master (
    input  rx_data_ready,
    input  rx_byte,
    input  rx_idle,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );

  modport slave (
    output rx_data_ready,
    output rx_byte,
    output rx_idle,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

endinterface

// File: rtl/uart_mem_loader.sv
// -----------------------------------------------------------------------------
// uart_mem_loader
// Boot/program loader: takes the UART receive byte stream, parses a frame of
//   word count (16-bit LE), N payload words (16-bit LE), XOR checksum byte
// and writes the payload words to memory starting at BASE_ADDR while holding
// the CPU stalled.
// Ports:
//   clk          : system clock
//   rst          : synchronous, active-high reset
//   load_req     : start a load (pulse or level), ignored while busy
//   bus          : uart_mem_loader_if.master (rx stream in, memory writes out)
//   cpu_hold     : keep the processor stalled while high
//   busy         : high while a frame is being parsed
//   load_done    : one-cycle pulse on a successful load
//   load_error   : sticky error flag, cleared by the next load_req
//   words_loaded : words written during the current load
// All outputs are registered.
// -----------------------------------------------------------------------------
module uart_mem_loader
  import uart_mem_loader_pkg::*;
#(
  parameter int ADDR_W    = 12,
  parameter int BASE_ADDR = 0,
  parameter int MAX_WORDS = 4096
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_req,
  uart_mem_loader_if.master       bus,
  output logic                    cpu_hold,
  output logic                    busy,
  output logic                    load_done,
  output logic                    load_error,
  output logic [15:0]             words_loaded
);

  localparam logic [ADDR_W-1:0] BASE    = ADDR_W'(BASE_ADDR);
  // One bit wider than the length field so MAX_WORDS = 65536 still compares.
  localparam logic [16:0]       MAX_LEN = 17'(MAX_WORDS);

  // Internal state
  state_t            state_r;
  logic [15:0]       len_r;
  logic [7:0]        low_r;
  logic [7:0]        chk_r;
  logic [ADDR_W-1:0] index_r;

  // Next-state values
  state_t            state_s;
  logic [15:0]       len_s;
  logic [7:0]        low_s;
  logic [7:0]        chk_s;
  logic [ADDR_W-1:0] index_s;
  logic              mem_we_s;
  logic [ADDR_W-1:0] mem_addr_s;
  logic [15:0]       mem_wdata_s;
  logic              cpu_hold_s;
  logic              load_done_s;
  logic              load_error_s;
  logic [15:0]       words_loaded_s;

  // Helpers on the incoming byte
  logic [15:0]       len_full_s;
  logic              len_bad_s;
  logic              last_word_s;
  logic [7:0]        chk_next_s;

  // Decode the header length and detect the final payload word.
  always_comb begin
    len_full_s  = {bus.rx_byte, len_r[7:0]};
    len_bad_s   = (len_full_s == 16'd0) || ({1'b0, len_full_s} > MAX_LEN);
    last_word_s = ((words_loaded + 16'd1) == len_r);
    chk_next_s  = chk_update(chk_r, bus.rx_byte);
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_s        = state_r;
    len_s          = len_r;
    low_s          = low_r;
    chk_s          = chk_r;
    index_s        = index_r;
    mem_we_s       = 1'b0;
    mem_addr_s     = bus.mem_addr;
    mem_wdata_s    = bus.mem_wdata;
    cpu_hold_s     = cpu_hold;
    load_done_s    = 1'b0;
    load_error_s   = load_error;
    words_loaded_s = words_loaded;

    case (state_r)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        // rx bytes arriving here are stray and dropped.
        if (load_req) begin
          state_s        = ST_LEN_LO;
          cpu_hold_s     = 1'b1;
          load_error_s   = 1'b0;
          words_loaded_s = 16'd0;
          chk_s          = 8'd0;
          index_s        = '0;
          len_s          = 16'd0;
        end else begin
          state_s = state_r;
        end
      end

      ST_LEN_LO: begin
        // No timeout here: the host may not have started sending yet.
        if (bus.rx_data_ready) begin
          len_s[7:0] = bus.rx_byte;
          state_s    = ST_LEN_HI;
        end else begin
          state_s = ST_LEN_LO;
        end
      end

      ST_LEN_HI: begin
        if (bus.rx_data_ready) begin
          len_s = len_full_s;
          if (len_bad_s) begin
            state_s      = ST_ERROR;
            load_error_s = 1'b1;
          end else begin
            state_s = ST_DATA_LO;
          end
        end else if (bus.rx_idle) begin
          state_s      = ST_ERROR;
          load_error_s = 1'b1;
        end else begin
          state_s = ST_LEN_HI;
        end
      end

      ST_DATA_LO: begin
        if (bus.rx_data_ready) begin
          low_s   = bus.rx_byte;
          chk_s   = chk_next_s;
          state_s = ST_DATA_HI;
        end else if (bus.rx_idle) begin
          state_s      = ST_ERROR;
          load_error_s = 1'b1;
        end else begin
          state_s = ST_DATA_LO;
        end
      end

      ST_DATA_HI: begin
        // The write strobe, address, data and counters all land on the same
        // clock edge, so words_loaded already includes the word being written.
        if (bus.rx_data_ready) begin
          chk_s          = chk_next_s;
          mem_we_s       = 1'b1;
          mem_addr_s     = BASE + index_r;
          mem_wdata_s    = {bus.rx_byte, low_r};
          index_s        = index_r + {{(ADDR_W-1){1'b0}}, 1'b1};
          words_loaded_s = words_loaded + 16'd1;
          if (last_word_s) begin
            state_s = ST_CHK;
          end else begin
            state_s = ST_DATA_LO;
          end
        end else if (bus.rx_idle) begin
          state_s      = ST_ERROR;
          load_error_s = 1'b1;
        end else begin
          state_s = ST_DATA_HI;
        end
      end

      ST_CHK: begin
        if (bus.rx_data_ready) begin
          if (bus.rx_byte == chk_r) begin
            state_s     = ST_DONE;
            load_done_s = 1'b1;
            cpu_hold_s  = 1'b0;
          end else begin
            state_s      = ST_ERROR;
            load_error_s = 1'b1;
          end
        end else if (bus.rx_idle) begin
          state_s      = ST_ERROR;
          load_error_s = 1'b1;
        end else begin
          state_s = ST_CHK;
        end
      end

      default: begin
        // Unreachable encoding: park in ERROR with the CPU held.
        state_s      = ST_ERROR;
        load_error_s = 1'b1;
        cpu_hold_s   = 1'b1;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      len_r        <= 16'd0;
      low_r        <= 8'd0;
      chk_r        <= 8'd0;
      index_r      <= '0;
      bus.mem_we   <= 1'b0;
      bus.mem_addr <= BASE;
      bus.mem_wdata <= 16'd0;
      cpu_hold     <= 1'b0;
      busy         <= 1'b0;
      load_done    <= 1'b0;
      load_error   <= 1'b0;
      words_loaded <= 16'd0;
    end else begin
      state_r      <= state_s;
      len_r        <= len_s;
      low_r        <= low_s;
      chk_r        <= chk_s;
      index_r      <= index_s;
      bus.mem_we   <= mem_we_s;
      bus.mem_addr <= mem_addr_s;
      bus.mem_wdata <= mem_wdata_s;
      cpu_hold     <= cpu_hold_s;
      busy         <= is_busy(state_s);
      load_done    <= load_done_s;
      load_error   <= load_error_s;
      words_loaded <= words_loaded_s;
    end
  end

endmodule

// File: doc/uart_mem_loader.md
Name: uart_mem_loader

Overview:
- Boot/program loader sequencing the UART receive path into processor memory.
- Consumes the receiver's byte stream (rx_data_ready, rx_byte, rx_idle) and assembles little-endian 16-bit words.
- Writes the words to instruction/data memory and holds the CPU while loading.
- Framing: 16-bit word count, N payload words, 1 XOR checksum byte.

Parameters:
ADDR_W, 12, memory word-address width
BASE_ADDR, 0, first memory word address written
MAX_WORDS, 4096, largest accepted word count; must satisfy BASE_ADDR+MAX_WORDS <= 2^ADDR_W

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
load_req  in  1  start a load; one-cycle pulse or level
rx_data_ready  in  1  one-cycle strobe, rx_byte valid
rx_byte  in  8  received byte
rx_idle  in  1  receiver line-idle (gap) indication
mem_we  out  1  memory write strobe, one cycle per word
mem_addr  out  ADDR_W  write word address
mem_wdata  out  16  write data, {high byte, low byte}
cpu_hold  out  1  keep processor stalled/reset while high
busy  out  1  high in any state other than IDLE/DONE/ERROR
load_done  out  1  one-cycle pulse on successful load
load_error  out  1  sticky error flag
words_loaded  out  16  count of words written in the current load

Behaviour:
- Clock and reset: single clock clk; reset is synchronous, active-high (rst).
- Reset values: state IDLE; mem_we=0, mem_addr=BASE_ADDR, mem_wdata=0, cpu_hold=0, busy=0, load_done=0, load_error=0, words_loaded=0; internal length, byte latch and checksum = 0.
- rst overrides everything, including mid-load; memory contents already written are not rolled back.
- States: IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI, CHK, DONE, ERROR.
- IDLE/DONE/ERROR:
  - load_req -> LEN_LO.
  - On entry: cpu_hold=1, load_error=0, words_loaded=0, checksum=0, index=0.
- State advance: every state below advances only on rx_data_ready.
- LEN_LO: latch len[7:0].
- LEN_HI: latch len[15:8].
  - len==0 or len>MAX_WORDS -> ERROR.
  - Otherwise -> DATA_LO.
- DATA_LO: latch low byte; checksum ^= byte; -> DATA_HI.
- DATA_HI: checksum ^= byte.
  - Next cycle: mem_we=1, mem_wdata={byte, low}, mem_addr=BASE_ADDR+index. Write latency is 1 cycle after the strobe.
  - index and words_loaded increment together with the mem_we cycle.
  - If this is word len -> CHK, else -> DATA_LO.
- CHK: byte == checksum -> DONE, else -> ERROR. Length bytes are excluded from the checksum.
- DONE entry:
  - load_done=1 for exactly one cycle.
  - cpu_hold=0 in the same cycle; busy=0.
- ERROR:
  - load_error=1 (sticky) and cpu_hold stays 1.
  - Left only by load_req or rst.
- Timeout: rx_idle=1 while in LEN_HI, DATA_LO, DATA_HI or CHK -> ERROR.
  - rx_idle is ignored in LEN_LO, because the host may not have started sending.
- Simultaneous rx_idle and rx_data_ready: the byte is consumed and rx_idle is ignored that cycle.
- load_req while busy: ignored.
- Bytes with no load in progress: rx_data_ready in IDLE/DONE/ERROR is ignored.
- No address wrap: the length check guarantees mem_addr never exceeds BASE_ADDR+MAX_WORDS-1.
- Widths: index is ADDR_W bits; len and words_loaded are 16 bits.

Decomposition:
- Shared package (uart_pkg): state encoding localparams and framing constants (header 2 bytes, trailer 1 byte).
- Flat module, no sub-module required.
- The byte-to-word assembler (DATA_LO/DATA_HI latch) is the only candidate for extraction, as uart_word_assembler, if reused by a future TX path.

Test Plan:
- Normal load: load_req, then bytes 02 00 34 12 78 56 08.
  - mem_we twice: addr 0 data 0x1234, addr 1 data 0x5678.
  - load_done pulse; cpu_hold falls; words_loaded=2.
- Bad checksum: same stream with final byte 09 -> both words written, load_error=1, cpu_hold stays 1, no load_done.
- Illegal length: bytes 00 00 -> ERROR immediately, no mem_we.
  - Repeat with MAX_WORDS=4 and length 05 00 -> ERROR, no mem_we.
- Timeout: 02 00 34, then rx_idle=1 -> ERROR, no mem_we.
  - A subsequent load_req with a valid stream -> load_error clears, load_done pulses.
- Reset mid-load: rst after 02 00 34 12 -> all outputs at reset values next cycle.
  - Stray trailing bytes are ignored in IDLE.
- Protocol corners:
  - load_req pulsed during DATA_LO: no restart, words_loaded continues.
  - rx_data_ready coincident with rx_idle in DATA_HI: word still written.
